// File: rtl/stg_pkg.sv
// Shared playfield types and helpers for the sprite motion controllers.
// Holds the phase codes, the coordinate width and the clamped single-step function.
package stg_pkg;

    localparam int COORD_W  = 10;
    localparam int PF_MAX_X = 384;
    localparam int PF_MAX_Y = 448;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        PH_SPAWN = 3'd0,
        PH_AIM   = 3'd1,
        PH_CHASE = 3'd2,
        PH_REST  = 3'd3,
        PH_FIRE  = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        DIR_ZERO = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_e;

    // Unsigned compare: coordinates are never treated as signed.
    function automatic dir_e dir_toward(input coord_t target, input coord_t pos);
        dir_e d;
        d = DIR_ZERO;
        if (target > pos) begin
            d = DIR_POS;
        end else if (target < pos) begin
            d = DIR_NEG;
        end
        return d;
    endfunction

    function automatic coord_t step_clamp(input coord_t pos, input dir_e dir, input coord_t lim);
        coord_t r;
        r = pos;
        case (dir)
            DIR_POS: r = (pos >= lim) ? lim : pos + coord_t'(1);
            DIR_NEG: r = (pos == '0) ? '0 : pos - coord_t'(1);
            default: r = pos;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/moon_motion_ctrl_if.sv
// Control/status bundle between the moon sequencer and its surroundings.
// The slave side is the sequencer; the master side is the game logic driving it.
interface moon_motion_ctrl_if;

    logic            enable;
    stg_pkg::coord_t player_x;
    stg_pkg::coord_t player_y;
    logic            fire_ack;
    stg_pkg::coord_t moon_x;
    stg_pkg::coord_t moon_y;
    logic [2:0]      phase;
    logic            tick;
    logic            fire_req;

    modport master (
        output enable, player_x, player_y, fire_ack,
        input  moon_x, moon_y, phase, tick, fire_req
    );

    modport slave (
        input  enable, player_x, player_y, fire_ack,
        output moon_x, moon_y, phase, tick, fire_req
    );

endinterface

// File: rtl/stg_tick_gen.sv
// Enable-gated game-tick divider: one-cycle strobe every TICK_DIV running cycles.
// The count freezes while paused, so the tick phase survives a pause.
module stg_tick_gen #(
    parameter int TICK_DIV = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(TICK_DIV - 1));
    assign tick = enable & wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/moon_motion_ctrl.sv
// Moon boss sequencer: spawn hold, aim, chase, rest, fire handshake, repeat.
// Single-clock; all motion is gated by the shared game-tick strobe.
module moon_motion_ctrl
    import stg_pkg::*;
#(
    parameter int TICK_DIV    = 2000000,
    parameter int MAX_X       = PF_MAX_X,
    parameter int MAX_Y       = PF_MAX_Y,
    parameter int START_X     = 192,
    parameter int START_Y     = 100,
    parameter int SPAWN_TICKS = 10,
    parameter int CHASE_STEPS = 128,
    parameter int REST_TICKS  = 50
) (
    input logic               clk,
    input logic               reset,
    moon_motion_ctrl_if.slave bus
);

    localparam int SPAWN_W = $clog2(SPAWN_TICKS) + 1;
    localparam int STEP_W  = $clog2(CHASE_STEPS) + 1;
    localparam int REST_W  = $clog2(REST_TICKS) + 1;

    localparam coord_t MAX_X_C   = coord_t'(MAX_X);
    localparam coord_t MAX_Y_C   = coord_t'(MAX_Y);
    localparam coord_t START_X_C = coord_t'(START_X);
    localparam coord_t START_Y_C = coord_t'(START_Y);

    phase_e             state_q, state_d;
    coord_t             x_q, x_d;
    coord_t             y_q, y_d;
    dir_e               dx_q, dx_d;
    dir_e               dy_q, dy_d;
    logic [SPAWN_W-1:0] spawn_cnt_q, spawn_cnt_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [REST_W-1:0]  rest_cnt_q, rest_cnt_d;

    logic              tick;
    coord_t            nx, ny;
    logic [STEP_W-1:0] step_nxt;
    logic              run_done;

    stg_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .tick   (tick)
    );

    assign nx       = step_clamp(x_q, dx_q, MAX_X_C);
    assign ny       = step_clamp(y_q, dy_q, MAX_Y_C);
    assign step_nxt = step_cnt_q + STEP_W'(1);

    // Evaluated on the post-step position, so a run started on a border and
    // clamped there still ends after its first tick.
    assign run_done = (nx == '0) || (nx == MAX_X_C) || (ny == '0) || (ny == MAX_Y_C)
                   || (step_nxt == STEP_W'(CHASE_STEPS))
                   || ((dx_q == DIR_ZERO) && (dy_q == DIR_ZERO));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        spawn_cnt_d = spawn_cnt_q;
        step_cnt_d  = step_cnt_q;
        rest_cnt_d  = rest_cnt_q;
        case (state_q)
            PH_SPAWN: begin
                if (tick) begin
                    if (spawn_cnt_q == SPAWN_W'(SPAWN_TICKS - 1)) begin
                        spawn_cnt_d = '0;
                        state_d     = PH_AIM;
                    end else begin
                        spawn_cnt_d = spawn_cnt_q + SPAWN_W'(1);
                    end
                end
            end
            PH_AIM: begin
                if (bus.enable) begin
                    dx_d       = dir_toward(bus.player_x, x_q);
                    dy_d       = dir_toward(bus.player_y, y_q);
                    step_cnt_d = '0;
                    state_d    = PH_CHASE;
                end
            end
            PH_CHASE: begin
                if (tick) begin
                    x_d        = nx;
                    y_d        = ny;
                    step_cnt_d = step_nxt;
                    if (run_done) begin
                        state_d = PH_REST;
                    end
                end
            end
            PH_REST: begin
                if (tick) begin
                    if (rest_cnt_q == REST_W'(REST_TICKS - 1)) begin
                        rest_cnt_d = '0;
                        state_d    = PH_FIRE;
                    end else begin
                        rest_cnt_d = rest_cnt_q + REST_W'(1);
                    end
                end
            end
            // The handshake completes even while paused.
            PH_FIRE: begin
                if (bus.fire_ack) begin
                    state_d = PH_AIM;
                end
            end
            default: state_d = PH_SPAWN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PH_SPAWN;
            x_q         <= START_X_C;
            y_q         <= START_Y_C;
            dx_q        <= DIR_ZERO;
            dy_q        <= DIR_ZERO;
            spawn_cnt_q <= '0;
            step_cnt_q  <= '0;
            rest_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            spawn_cnt_q <= spawn_cnt_d;
            step_cnt_q  <= step_cnt_d;
            rest_cnt_q  <= rest_cnt_d;
        end
    end

    assign bus.moon_x   = x_q;
    assign bus.moon_y   = y_q;
    assign bus.phase    = state_q;
    assign bus.tick     = tick;
    assign bus.fire_req = (state_q == PH_FIRE);

endmodule

// File: doc/moon_motion_ctrl.md
Name: moon_motion_ctrl

Overview:
- Sequencer for the moon boss sprite. Owns the moon's playfield position and runs a phase FSM: spawn hold, aim at player, chase, rest on border, fire handshake, repeat.
- Sits between the game-tick timebase and the moon renderer (consumes moon_x/moon_y) and the bullet spawner (fire_req/fire_ack).
- Replaces ad-hoc tick-clocked movement with a single-clock, enable-gated controller.

Parameters:
TICK_DIV, 2000000, clk cycles per game tick (>=2)
MAX_X, 384, playfield right/x border
MAX_Y, 448, playfield bottom/y border
START_X, 192, reset/spawn x
START_Y, 100, reset/spawn y
SPAWN_TICKS, 10, ticks held at spawn before first aim
CHASE_STEPS, 128, max 1-pixel steps per chase run
REST_TICKS, 50, ticks parked after chase ends

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  1 = run; 0 = freeze (pause)
player_x  in  10  player centre x
player_y  in  10  player centre y
fire_ack  in  1  bullet spawner accepted request
moon_x  out  10  moon centre x
moon_y  out  10  moon centre y
phase  out  3  current FSM state code
tick  out  1  one-cycle game-tick strobe
fire_req  out  1  request bullet burst at moon position

Behaviour:
- Reset (reset=0, async): moon_x=START_X, moon_y=START_Y, phase=SPAWN, tick=0, fire_req=0, all counters 0. Leaves reset on the first clk edge with reset=1.
- Tick counter: counts 0..TICK_DIV-1 while enable=1, then wraps. tick=1 for exactly the cycle the count equals TICK_DIV-1.
- enable=0: tick counter, FSM, position and step/rest counters all hold. fire_req holds its value. A fire_ack seen while paused is still honoured.
- All state transitions are registered. Position changes only on tick cycles in CHASE.
- Phase codes: SPAWN=0, AIM=1, CHASE=2, REST=3, FIRE=4.
- SPAWN: count ticks. On the SPAWN_TICKS-th tick go to AIM.
- AIM: one clk cycle, no tick needed.
  - Latch dir_x = +1 if player_x>moon_x, -1 if <, 0 if equal. dir_y likewise.
  - Compare unsigned 10-bit, with no signed reinterpretation.
  - Clear the step counter. Go to CHASE.
- CHASE, on each tick:
  - moon_x += dir_x and moon_y += dir_y, each clamped to [0,MAX_X] and [0,MAX_Y].
  - Increment the step counter.
  - After the update, go to REST if any of: the position is on a border (x==0, x==MAX_X, y==0 or y==MAX_Y); step count == CHASE_STEPS; or dir_x==dir_y==0 (the zero-direction check applies on the first tick).
- Direction is not re-sampled during CHASE; player motion is ignored until the next AIM.
- REST: position held. After REST_TICKS ticks go to FIRE.
- FIRE:
  - fire_req=1 from state entry and held until the cycle fire_ack=1 is sampled.
  - Next cycle: fire_req=0 and phase=AIM.
  - fire_ack is ignored in every other state.
  - fire_ack already high on the entry cycle completes in one cycle (req high for one cycle).
- Border-start case: AIM→CHASE from a border position with a direction pointing inward takes one step. The moon is then off the border and continues normally.
  - If clamping leaves it on the border, the run ends after one tick. There is no livelock.
- Arithmetic: position is 10-bit. Clamp before writeback. Step/rest/spawn counters are sized by $clog2 of their parameter + 1.
- Reset mid-FIRE drops fire_req asynchronously.

Decomposition:
- Shared package stg_pkg: phase enum/localparams (SPAWN..FIRE), playfield constants MAX_X/MAX_Y, 10-bit coordinate width.
- Sub-module: stg_tick_gen (parameter TICK_DIV; ports clk, reset, enable, tick). Reusable by other enemies.

Test Plan (TICK_DIV=4, SPAWN_TICKS=2, CHASE_STEPS=5, REST_TICKS=3 unless stated):
- Reset then enable=1, player=(300,100):
  - Required: phase SPAWN for 8 clk, then AIM for 1 clk.
  - Then CHASE: moon_x 193,194,...,197 on successive ticks, moon_y stays 100.
  - REST after the 5th step. FIRE 12 clk later.
- FIRE with fire_ack held low 10 cycles, then pulsed:
  - Required: fire_req stays 1 throughout.
  - fire_req drops the cycle after ack. phase=AIM then.
- START=(2,2), player=(0,0):
  - Required: steps to (1,1), then (0,0).
  - Border reached → REST after 2 steps, not 5.
- Player exactly at moon position:
  - Required: one CHASE tick with no movement, then REST.
- enable=0 for 20 cycles mid-CHASE:
  - Required: tick stays 0; moon_x/moon_y/phase unchanged.
  - On resume, the remaining steps complete with the original tick phase preserved.
- reset=0 pulsed mid-FIRE:
  - Required: fire_req=0 immediately.
  - Position (192,100), phase SPAWN.
